// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU. One operation is in flight at a time,
// with an optional multi-cycle hold and a registered result that stays valid until the requester consumes it.
module alu_arbiter #(
  parameter int unsigned MCP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_b,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_vin,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_vin,

  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_din_a,
  output logic [31:0] alu_din_b,
  output logic        alu_cin,
  output logic        alu_vin,
  input  logic [31:0] alu_dout,
  input  logic        alu_cout,
  input  logic        alu_vout,
  input  logic        alu_mcp,

  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_dout,
  output logic        rsp_cout,
  output logic        rsp_vout,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MCP_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant;
  logic        sel;
  logic        accept;
  logic        rsp_hs;
  logic        load_cnt;
  logic        capture;
  logic [3:0]  cnt;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign req0_ready = reset_b && (state == IDLE) && req0_valid && !sel;
  assign req1_ready = reset_b && (state == IDLE) && req1_valid &&  sel;
  assign accept     = req0_ready || req1_ready;

  // Only the granted requester's consume strobe can release RESP.
  assign rsp_hs     = grant ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (alu_mcp) begin
          load_cnt  = 1'b1;
          state_nxt = WAIT;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      alu_opcode <= '0;
      alu_din_a  <= '0;
      alu_din_b  <= '0;
      alu_cin    <= 1'b0;
      alu_vin    <= 1'b0;
      rsp_dout   <= '0;
      rsp_cout   <= 1'b0;
      rsp_vout   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        grant      <= sel;
        last_grant <= sel;
        alu_opcode <= sel ? req1_opcode : req0_opcode;
        alu_din_a  <= sel ? req1_a      : req0_a;
        alu_din_b  <= sel ? req1_b      : req0_b;
        alu_cin    <= sel ? req1_cin    : req0_cin;
        alu_vin    <= sel ? req1_vin    : req0_vin;
      end

      if (load_cnt) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        rsp_dout <= alu_dout;
        rsp_cout <= alu_cout;
        rsp_vout <= alu_vout;
      end
    end
  end

  assign rsp0_valid = (state == RESP) && !grant;
  assign rsp1_valid = (state == RESP) &&  grant;
  assign busy       = (state != IDLE);

  a_one_ready: assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_reset_ready: assert property (@(posedge clk) !reset_b |-> !(req0_ready || req1_ready));
  a_one_rsp: assert property (@(posedge clk) !(rsp0_valid && rsp1_valid));

endmodule
